// File: rtl/axi_adc_jesd204_pnmon.sv
// Per-channel PN9/PN23/ramp test-pattern monitor for one deframed JESD204 ADC channel.
// Self-synchronises while out of sync, free-runs its own generator once locked.
module axi_adc_jesd204_pnmon #(
   parameter int CHANNEL_WIDTH   = 16,
   parameter int DATA_PATH_WIDTH = 2,
   parameter int OOS_THRESHOLD   = 16
) (
   input  logic                                       adc_clk,
   input  logic                                       adc_resetn,
   input  logic                                       adc_valid,
   input  logic [DATA_PATH_WIDTH*CHANNEL_WIDTH-1:0]   adc_data,
   input  logic [1:0]                                 adc_pn_sel,
   input  logic                                       adc_pn_clr,
   output logic                                       adc_pn_oos,
   output logic                                       adc_pn_err,
   output logic [31:0]                                adc_pn_err_count
);

   localparam int W     = DATA_PATH_WIDTH * CHANNEL_WIDTH;
   localparam int CNT_W = $clog2(OOS_THRESHOLD + 1);
   localparam logic [CNT_W-1:0] THR_M1 = CNT_W'(OOS_THRESHOLD - 1);

   localparam logic [0:0] ST_OOS  = 1'b0;
   localparam logic [0:0] ST_SYNC = 1'b1;

   // Reverses bit order inside each sample; maps a word to/from stream order (index 0 = first bit).
   function automatic logic [W-1:0] bit_swap(input logic [W-1:0] w);
      logic [W-1:0] r;
      r = '0;
      for (int j = 0; j < DATA_PATH_WIDTH; j++) begin
         for (int i = 0; i < CHANNEL_WIDTH; i++) begin
            r[j*CHANNEL_WIDTH + i] = w[j*CHANNEL_WIDTH + CHANNEL_WIDTH - 1 - i];
         end
      end
      return r;
   endfunction

   function automatic logic [W-1:0] pn_next(input logic [W-1:0] seed, input logic pn23);
      logic [W-1:0]  t;
      logic [W+22:0] h;
      t       = bit_swap(seed);
      h       = '0;
      h[22:0] = t[W-1:W-23];
      for (int n = 23; n < W + 23; n++) begin
         h[n] = pn23 ? (h[n-23] ^ h[n-18]) : (h[n-9] ^ h[n-5]);
      end
      return bit_swap(h[W+22:23]);
   endfunction

   function automatic logic [W-1:0] ramp_next(input logic [W-1:0] seed);
      logic [W-1:0]             r;
      logic [CHANNEL_WIDTH-1:0] last;
      last = seed[W-1 -: CHANNEL_WIDTH];
      r    = '0;
      for (int j = 0; j < DATA_PATH_WIDTH; j++) begin
         r[j*CHANNEL_WIDTH +: CHANNEL_WIDTH] = last + CHANNEL_WIDTH'(j + 1);
      end
      return r;
   endfunction

   logic [0:0]       state_q, state_d;
   logic [W-1:0]     seed_q, seed_d;
   logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
   logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
   logic [1:0]       sel_q;
   logic             oos_q;
   logic             err_q, err_d;
   logic [31:0]      err_cnt_q, err_cnt_d;

   logic             ramp_s, pn23_s, sel_chg_s, match_s;
   logic [W-1:0]     exp_s;

   // Expected word and match decision; reserved select falls through to PN9.
   always_comb begin
      ramp_s    = (adc_pn_sel == 2'd2);
      pn23_s    = (adc_pn_sel == 2'd1);
      sel_chg_s = (adc_pn_sel != sel_q);
      exp_s     = ramp_s ? ramp_next(seed_q) : pn_next(seed_q, pn23_s);
      match_s   = (adc_data == exp_s) && (ramp_s || (adc_data != '0));
   end

   // Lock state machine, seed selection and error accounting.
   always_comb begin
      state_d     = state_q;
      seed_d      = seed_q;
      match_cnt_d = match_cnt_q;
      miss_cnt_d  = miss_cnt_q;
      err_d       = 1'b0;
      if (sel_chg_s) begin
         state_d     = ST_OOS;
         seed_d      = '0;
         match_cnt_d = '0;
         miss_cnt_d  = '0;
      end else if (adc_valid) begin
         case (state_q)
            ST_OOS: begin
               seed_d = adc_data;
               if (!match_s) begin
                  match_cnt_d = '0;
               end else if (match_cnt_q == THR_M1) begin
                  state_d     = ST_SYNC;
                  match_cnt_d = '0;
                  miss_cnt_d  = '0;
               end else begin
                  match_cnt_d = match_cnt_q + CNT_W'(1);
               end
            end
            ST_SYNC: begin
               // Locked: follow the internal generator so one bad word cannot corrupt the next.
               seed_d = exp_s;
               if (match_s) begin
                  miss_cnt_d = '0;
               end else begin
                  err_d = 1'b1;
                  if (miss_cnt_q == THR_M1) begin
                     state_d     = ST_OOS;
                     match_cnt_d = '0;
                     miss_cnt_d  = '0;
                  end else begin
                     miss_cnt_d = miss_cnt_q + CNT_W'(1);
                  end
               end
            end
            default: begin
               state_d = ST_OOS;
            end
         endcase
      end else begin
         state_d = state_q;
      end

      if (adc_pn_clr) begin
         err_cnt_d = 32'd0;
      end else if (err_d && (err_cnt_q != 32'hFFFF_FFFF)) begin
         err_cnt_d = err_cnt_q + 32'd1;
      end else begin
         err_cnt_d = err_cnt_q;
      end
   end

   // State and output registers.
   always_ff @(posedge adc_clk or negedge adc_resetn) begin
      if (!adc_resetn) begin
         state_q     <= ST_OOS;
         seed_q      <= '0;
         match_cnt_q <= '0;
         miss_cnt_q  <= '0;
         sel_q       <= 2'd0;
         oos_q       <= 1'b1;
         err_q       <= 1'b0;
         err_cnt_q   <= 32'd0;
      end else begin
         state_q     <= state_d;
         seed_q      <= seed_d;
         match_cnt_q <= match_cnt_d;
         miss_cnt_q  <= miss_cnt_d;
         sel_q       <= adc_pn_sel;
         oos_q       <= (state_d == ST_OOS);
         err_q       <= err_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign adc_pn_oos       = oos_q;
   assign adc_pn_err       = err_q;
   assign adc_pn_err_count = err_cnt_q;

endmodule

// File: tb/tb_axi_adc_jesd204_pnmon.sv
// Directed bench for axi_adc_jesd204_pnmon: PN9/PN23/ramp lock, error reporting and controls.
module tb_axi_adc_jesd204_pnmon;

   localparam int CW = 16;
   localparam int DW = 2;
   localparam int W  = CW * DW;

   logic          adc_clk = 1'b0;
   logic          adc_resetn;
   logic          adc_valid;
   logic [W-1:0]  adc_data;
   logic [1:0]    adc_pn_sel;
   logic          adc_pn_clr;
   logic          adc_pn_oos;
   logic          adc_pn_err;
   logic [31:0]   adc_pn_err_count;

   int            n_vec  = 0;
   int            n_miss = 0;

   logic [22:0]   hist = '1;
   logic          pn23_mode = 1'b0;
   logic [CW-1:0] ramp_v;
   logic [W-1:0]  w;

   axi_adc_jesd204_pnmon #(
      .CHANNEL_WIDTH   (CW),
      .DATA_PATH_WIDTH (DW),
      .OOS_THRESHOLD   (16)
   ) dut (
      .adc_clk          (adc_clk),
      .adc_resetn       (adc_resetn),
      .adc_valid        (adc_valid),
      .adc_data         (adc_data),
      .adc_pn_sel       (adc_pn_sel),
      .adc_pn_clr       (adc_pn_clr),
      .adc_pn_oos       (adc_pn_oos),
      .adc_pn_err       (adc_pn_err),
      .adc_pn_err_count (adc_pn_err_count)
   );

   always #5 adc_clk = ~adc_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // Bit-serial reference generator; first stream bit lands in the MSB of sample 0.
   task automatic pn_word(output logic [W-1:0] r);
      logic nb;
      r = '0;
      for (int k = 0; k < W; k++) begin
         nb   = pn23_mode ? (hist[22] ^ hist[17]) : (hist[8] ^ hist[4]);
         hist = {hist[21:0], nb};
         r[(k / CW) * CW + CW - 1 - (k % CW)] = nb;
      end
   endtask

   task automatic ramp_word(output logic [W-1:0] r);
      r      = {ramp_v + 16'd1, ramp_v};
      ramp_v = ramp_v + 16'd2;
   endtask

   // Called at a negedge: drive, take one rising edge, return at the following negedge.
   task automatic step(input logic v, input logic [W-1:0] d);
      adc_valid = v;
      adc_data  = d;
      @(posedge adc_clk);
      @(negedge adc_clk);
   endtask

   initial begin
      adc_resetn = 1'b0;
      adc_valid  = 1'b0;
      adc_data   = '0;
      adc_pn_sel = 2'd0;
      adc_pn_clr = 1'b0;
      repeat (2) @(negedge adc_clk);
      chk("rst_oos", 32'(adc_pn_oos), 32'd1);
      chk("rst_err", 32'(adc_pn_err), 32'd0);
      chk("rst_cnt", adc_pn_err_count, 32'd0);
      adc_resetn = 1'b1;
      @(negedge adc_clk);

      // PN9 lock: word 1 only seeds, words 2..17 match
      for (int i = 1; i <= 17; i++) begin
         pn_word(w);
         step(1'b1, w);
         if (i == 16) chk("pn9_pre_lock", 32'(adc_pn_oos), 32'd1);
      end
      chk("pn9_lock", 32'(adc_pn_oos), 32'd0);
      for (int i = 0; i < 4; i++) begin
         pn_word(w);
         step(1'b1, w);
         chk("pn9_run_err", 32'(adc_pn_err), 32'd0);
      end
      chk("pn9_run_cnt", adc_pn_err_count, 32'd0);

      // single bit error in SYNC
      pn_word(w);
      step(1'b1, w ^ 32'h0000_0100);
      chk("single_err", 32'(adc_pn_err), 32'd1);
      chk("single_cnt", adc_pn_err_count, 32'd1);
      pn_word(w);
      step(1'b1, w);
      chk("single_next_err", 32'(adc_pn_err), 32'd0);
      chk("single_next_oos", 32'(adc_pn_oos), 32'd0);
      chk("single_next_cnt", adc_pn_err_count, 32'd1);

      // clear then burst of 16 bad words
      adc_pn_clr = 1'b1;
      step(1'b0, '0);
      adc_pn_clr = 1'b0;
      chk("clr_cnt", adc_pn_err_count, 32'd0);
      for (int i = 1; i <= 16; i++) begin
         pn_word(w);
         step(1'b1, w ^ 32'h0001_0001);
         if (i == 15) chk("burst_oos15", 32'(adc_pn_oos), 32'd0);
      end
      chk("burst_oos16", 32'(adc_pn_oos), 32'd1);
      chk("burst_err16", 32'(adc_pn_err), 32'd1);
      chk("burst_cnt", adc_pn_err_count, 32'd16);

      // PN23 relock after select change
      adc_pn_sel = 2'd1;
      pn23_mode  = 1'b1;
      step(1'b0, '0);
      for (int i = 1; i <= 17; i++) begin
         pn_word(w);
         step(1'b1, w);
         if (i == 16) chk("pn23_pre_lock", 32'(adc_pn_oos), 32'd1);
      end
      chk("pn23_lock", 32'(adc_pn_oos), 32'd0);
      chk("pn23_cnt", adc_pn_err_count, 32'd16);

      // select change while locked forces OOS next cycle
      adc_pn_sel = 2'd2;
      pn_word(w);
      step(1'b1, w);
      chk("selchg_oos", 32'(adc_pn_oos), 32'd1);
      chk("selchg_err", 32'(adc_pn_err), 32'd0);

      // ramp with gaps, wrapping 0xFFFF -> 0x0000 inside the lock sequence
      ramp_v = 16'hFFE0;
      begin
         int v;
         int i;
         v = 0;
         i = 0;
         while (v < 17) begin
            if (i % 3 == 2) begin
               step(1'b0, W'($urandom));
               chk("ramp_gap_err", 32'(adc_pn_err), 32'd0);
            end else begin
               ramp_word(w);
               step(1'b1, w);
               v++;
               if (v == 16) chk("ramp_pre_lock", 32'(adc_pn_oos), 32'd1);
            end
            i++;
         end
      end
      chk("ramp_lock", 32'(adc_pn_oos), 32'd0);
      chk("ramp_cnt", adc_pn_err_count, 32'd16);
      for (int i = 0; i < 3; i++) begin
         ramp_word(w);
         step(1'b1, w);
         chk("ramp_run_err", 32'(adc_pn_err), 32'd0);
      end

      // clear wins over a simultaneous increment
      adc_pn_clr = 1'b1;
      ramp_word(w);
      step(1'b1, w ^ 32'h0000_0010);
      adc_pn_clr = 1'b0;
      chk("clr_mis_cnt", adc_pn_err_count, 32'd0);
      chk("clr_mis_err", 32'(adc_pn_err), 32'd1);
      ramp_word(w);
      step(1'b1, w);
      chk("clr_next_err", 32'(adc_pn_err), 32'd0);

      // saturation near 0xFFFFFFFF
      force dut.err_cnt_q = 32'hFFFF_FFFD;
      #1 release dut.err_cnt_q;
      ramp_word(w);
      step(1'b1, w ^ 32'h8000_0000);
      chk("sat_1", adc_pn_err_count, 32'hFFFF_FFFE);
      ramp_word(w);
      step(1'b1, w ^ 32'h8000_0000);
      chk("sat_2", adc_pn_err_count, 32'hFFFF_FFFF);
      ramp_word(w);
      step(1'b1, w ^ 32'h8000_0000);
      chk("sat_3", adc_pn_err_count, 32'hFFFF_FFFF);
      chk("sat_oos", 32'(adc_pn_oos), 32'd0);

      // all-zero data in PN9 never locks and never counts
      adc_pn_sel = 2'd0;
      pn23_mode  = 1'b0;
      adc_pn_clr = 1'b1;
      step(1'b0, '0);
      adc_pn_clr = 1'b0;
      for (int i = 0; i < 100; i++) begin
         step(1'b1, '0);
         chk("zero_oos", 32'(adc_pn_oos), 32'd1);
      end
      chk("zero_cnt", adc_pn_err_count, 32'd0);

      // asynchronous reset in SYNC with an error pending
      for (int i = 0; i < 17; i++) begin
         pn_word(w);
         step(1'b1, w);
      end
      chk("relock_oos", 32'(adc_pn_oos), 32'd0);
      pn_word(w);
      step(1'b1, ~w);
      chk("pre_rst_err", 32'(adc_pn_err), 32'd1);
      #2 adc_resetn = 1'b0;
      #1;
      chk("async_rst_oos", 32'(adc_pn_oos), 32'd1);
      chk("async_rst_err", 32'(adc_pn_err), 32'd0);
      chk("async_rst_cnt", adc_pn_err_count, 32'd0);
      @(negedge adc_clk);
      adc_resetn = 1'b1;
      @(negedge adc_clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
